// File: rtl/calc_result_display.sv
// -----------------------------------------------------------------------------
// calc_result_display
//   Display-side consumer of the calculator result. Each new binary result is
//   converted to BCD by a sequential shift-add-3 (double-dabble) engine, and the
//   last completed BCD value is time-multiplexed onto one 7-segment display.
//
// Ports
//   clock        in   1           rising-edge clock
//   Reset        in   1           asynchronous, active-high reset
//   value_in     in   WIDTH       result to display
//   value_valid  in   1           one-cycle strobe: value_in is a new result
//   busy         out  1           conversion in progress
//   bcd_out      out  4*DIGITS    last completed BCD value, units in [3:0]
//   bcd_valid    out  1           one-cycle pulse when bcd_out updates
//   seg_out      out  7           segments {g,f,e,d,c,b,a}, active-high
//   digit_sel    out  DIGITS      one-hot digit enable, bit0 = units
// -----------------------------------------------------------------------------
module calc_result_display #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 16,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clock,
    input  logic                  Reset,
    input  logic [WIDTH-1:0]      value_in,
    input  logic                  value_valid,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  bcd_valid,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     digit_sel
);

    localparam int CNT_W  = $clog2(WIDTH + 1);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BCD_W  = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] w);
        logic [BCD_W-1:0] r;
        logic [3:0]       n;
        r = w;
        for (int i = 0; i < DIGITS; i++) begin
            n = w[4*i +: 4];
            if (n >= 4'd5) begin
                r[4*i +: 4] = n + 4'd3;
            end else begin
                r[4*i +: 4] = n;
            end
        end
        return r;
    endfunction

    // BCD digit to active-high segments {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   work_q, work_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               bcd_valid_q, bcd_valid_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic               pend_valid_q, pend_valid_d;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               busy_s;

    assign busy_s = (state_q != ST_IDLE);

    // Conversion FSM, pending-result capture and digit scan: next-state logic.
    always_comb begin
        state_d      = state_q;
        bin_d        = bin_q;
        work_d       = work_q;
        cnt_d        = cnt_q;
        bcd_d        = bcd_q;
        bcd_valid_d  = 1'b0;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        scan_d       = scan_q + SCAN_W'(1);
        idx_d        = idx_q;

        case (state_q)
            ST_IDLE: begin
                if (value_valid) begin
                    bin_d   = value_in;
                    work_d  = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else if (pend_valid_q) begin
                    bin_d        = pend_q;
                    work_d       = '0;
                    cnt_d        = '0;
                    pend_valid_d = 1'b0;
                    state_d      = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // Correct first, then shift the combined {work,bin} register.
                {work_d, bin_d} = {add3(work_q), bin_q} << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_DONE: begin
                bcd_d       = work_q;
                bcd_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A result arriving mid-conversion waits in a 1-deep slot; last one wins.
        if (busy_s && value_valid) begin
            pend_d       = value_in;
            pend_valid_d = 1'b1;
        end else begin
            pend_d = pend_d;
        end

        if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
            scan_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            bin_q        <= '0;
            work_q       <= '0;
            cnt_q        <= '0;
            bcd_q        <= '0;
            bcd_valid_q  <= 1'b0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            scan_q       <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            work_q       <= work_d;
            cnt_q        <= cnt_d;
            bcd_q        <= bcd_d;
            bcd_valid_q  <= bcd_valid_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            scan_q       <= scan_d;
            idx_q        <= idx_d;
        end
    end

    // Segment decode for the selected digit, with optional leading-zero blanking.
    always_comb begin
        logic upper_nz;
        upper_nz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(idx_q)) && (bcd_q[4*i +: 4] != 4'd0)) begin
                upper_nz = 1'b1;
            end else begin
                upper_nz = upper_nz;
            end
        end
        // Units digit is never blanked so a zero result still shows "0".
        if ((BLANK_LZ != 0) && (idx_q != '0) && !upper_nz) begin
            seg_out = 7'h00;
        end else begin
            seg_out = seg7(bcd_q[{idx_q, 2'b00} +: 4]);
        end
    end

    assign digit_sel = DIGITS'(1) << idx_q;
    assign busy      = busy_s;
    assign bcd_out   = bcd_q;
    assign bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_calc_result_display.sv
module tb_calc_result_display;

    logic        clock = 1'b0;
    logic        Reset = 1'b1;
    logic [7:0]  value_in = 8'd0;
    logic        value_valid = 1'b0;

    logic        busy_a, bcd_valid_a, busy_b, bcd_valid_b;
    logic [11:0] bcd_out_a, bcd_out_b;
    logic [6:0]  seg_a, seg_b;
    logic [2:0]  sel_a, sel_b;

    calc_result_display dut_a (
        .clock(clock), .Reset(Reset), .value_in(value_in), .value_valid(value_valid),
        .busy(busy_a), .bcd_out(bcd_out_a), .bcd_valid(bcd_valid_a),
        .seg_out(seg_a), .digit_sel(sel_a)
    );

    calc_result_display #(.WIDTH(8), .DIGITS(3), .SCAN_DIV(4), .BLANK_LZ(0)) dut_b (
        .clock(clock), .Reset(Reset), .value_in(value_in), .value_valid(value_valid),
        .busy(busy_b), .bcd_out(bcd_out_b), .bcd_valid(bcd_valid_b),
        .seg_out(seg_b), .digit_sel(sel_b)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state (transaction level: edge count, end edge of the
    // running conversion, one pending slot, value currently displayed).
    int cyc    = 0;
    int end_e  = -100;
    int cur    = 0;
    int shown  = 0;
    int pv     = 0;
    bit pend   = 1'b0;
    bit exp_valid = 1'b0;
    int scan_n = 0;
    int q[$];

    int seg_tab[10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
    int pow10[3]    = '{1, 10, 100};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int exp_seg(input int v, input int idx, input bit blank);
        if (blank && idx > 0 && v < pow10[idx]) return 0;
        return seg_tab[(v / pow10[idx]) % 10];
    endfunction

    // Behavioural model: a conversion ends 9 edges after it starts; strobes
    // during a conversion go to the pending slot and start right after.
    initial begin
        forever begin
            @(posedge clock or posedge Reset);
            if (Reset) begin
                cyc = 0; end_e = -100; cur = 0; shown = 0; pend = 1'b0;
                exp_valid = 1'b0; scan_n = 0; q.delete();
            end else begin
                cyc++;
                scan_n++;
                exp_valid = (cyc == end_e);
                if (exp_valid) shown = cur;
                if (cyc <= end_e) begin
                    if (value_valid) begin
                        pend = 1'b1;
                        pv = int'(value_in);
                    end
                end else if (value_valid) begin
                    cur = int'(value_in); end_e = cyc + 9; q.push_back(cur);
                end else if (pend) begin
                    cur = pv; end_e = cyc + 9; q.push_back(cur); pend = 1'b0;
                end
            end
        end
    end

    // Monitor: compares outputs on the falling edge; pops the scoreboard on bcd_valid.
    initial begin
        int idx_a, idx_b, v;
        forever begin
            @(negedge clock);
            check("busy", int'(busy_a), int'(cyc < end_e));
            check("bcd_valid", int'(bcd_valid_a), int'(exp_valid));
            check("bcd_out", int'(bcd_out_a), to_bcd(shown));
            if (bcd_valid_a) begin
                if (q.size() == 0) begin
                    check("sb_unexpected_valid", q.size(), 1);
                end else begin
                    v = q.pop_front();
                    check("sb_bcd", int'(bcd_out_a), to_bcd(v));
                end
            end
            idx_a = (scan_n / 16) % 3;
            idx_b = (scan_n / 4) % 3;
            check("digit_sel_a", int'(sel_a), 1 << idx_a);
            check("seg_a", int'(seg_a), exp_seg(shown, idx_a, 1'b1));
            check("digit_sel_b", int'(sel_b), 1 << idx_b);
            check("seg_b", int'(seg_b), exp_seg(shown, idx_b, 1'b0));
            check("bcd_out_b", int'(bcd_out_b), to_bcd(shown));
        end
    end

    // Drive inputs for the next rising edge.
    task automatic tick(input bit v, input int val);
        @(negedge clock);
        #1;
        value_valid = v;
        value_in    = val[7:0];
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 0);
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic async_reset();
        @(negedge clock);
        #2;
        value_valid = 1'b0;
        Reset = 1'b1;
        #1;
        check("rst_busy", int'(busy_a), 0);
        check("rst_bcd_out", int'(bcd_out_a), 0);
        check("rst_digit_sel", int'(sel_a), 1);
        check("rst_seg", int'(seg_a), 'h3F);
        @(negedge clock);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        bit v;
        repeat (3) @(negedge clock);
        #1;
        Reset = 1'b0;
        idle(4);

        // 255 -> 2,5,5
        tick(1'b1, 255);
        idle(60);

        // 0 -> units only (blanked), all zeros on the unblanked instance
        tick(1'b1, 0);
        idle(60);

        // 7, then 42 and 99 while busy: 42 is overwritten by 99
        tick(1'b1, 7);
        idle(2);
        tick(1'b1, 42);
        idle(1);
        tick(1'b1, 99);
        idle(60);

        // Reset during a 128 conversion with a pending value queued
        async_reset();
        idle(2);
        tick(1'b1, 128);
        tick(1'b1, 50);
        idle(2);
        async_reset();
        idle(40);

        // Mid-run reset with a value on display
        tick(1'b1, 205);
        idle(20);
        async_reset();
        idle(5);

        // Random strobes, never in IDLE while a pending value is waiting
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 6) == 0);
            if (pend && (cyc + 1 > end_e)) v = 1'b0;
            tick(v, $urandom_range(0, 255));
        end
        idle(40);

        check("sb_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
